// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_scan
//   Row-multiplexed 8x8 LED matrix driver fed by the tetris core's row images.
//   A snapshot of all eight rows is taken once per frame (LOAD), so core
//   updates never tear mid-frame. Each row is preceded by a blanking gap
//   (BLANK) and then lit for a fixed dwell (ON).
//
//   Optional build macro: SCAN_DIM_EN
//     Adds a 3-bit 'bright' input sampled in LOAD. During ON, column data is
//     gated by the low three bits of the dwell counter against that value.
//     bright = 7 gives full duty and bright = 0 gives 1/8 duty.
//
// Parameters
//   DWELL_CYC  cycles each row is lit (>= 1)
//   BLANK_CYC  cycles of all-off between rows (0 = no blanking)
//
// Ports
//   CLK         system clock, rising edge
//   CLR         asynchronous active-low reset
//   map0..map7  row images, bit7 = leftmost column
//   bright      (SCAN_DIM_EN only) per-frame brightness level
//   row_sel     one-hot row enable, registered
//   col         column data for the lit row, registered
//   frame_sync  one-cycle pulse while the freshly loaded snapshot is first valid
// ---------------------------------------------------------------------------
module led_matrix_scan #(
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] map0,
  input  logic [7:0] map1,
  input  logic [7:0] map2,
  input  logic [7:0] map3,
  input  logic [7:0] map4,
  input  logic [7:0] map5,
  input  logic [7:0] map6,
  input  logic [7:0] map7,
`ifdef SCAN_DIM_EN
  input  logic [2:0] bright,
`endif
  output logic [7:0] row_sel,
  output logic [7:0] col,
  output logic       frame_sync
);

  localparam int MAX_DB = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int MAX_V  = (MAX_DB > 2) ? MAX_DB : 2;
  localparam int CNT_W  = $clog2(MAX_V);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  // BLANK is unreachable when BLANK_CYC = 0; clamp to keep the constant legal.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_e;

  // State entered after LOAD or after a non-final row.
  localparam state_e AFTER_ROW = (BLANK_CYC == 0) ? S_ON : S_BLANK;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0][7:0] buf_q, buf_d;
  logic [7:0]      row_sel_q, row_sel_d;
  logic [7:0]      col_q, col_d;
  logic            fs_q, fs_d;

`ifdef SCAN_DIM_EN
  logic [2:0] bright_q, bright_d;
  logic [2:0] dim_phase_s;

  // Low three bits of the next dwell count; zero-extended for narrow counters.
  if (CNT_W >= 3) begin : g_phase_wide
    assign dim_phase_s = cnt_d[2:0];
  end else begin : g_phase_narrow
    assign dim_phase_s = 3'(cnt_d);
  end
`endif

  // Next-state, counter, snapshot and registered-output computation.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q + CNT_ONE;
    buf_d     = buf_q;
    fs_d      = 1'b0;
    row_sel_d = 8'h00;
    col_d     = 8'h00;
`ifdef SCAN_DIM_EN
    bright_d  = bright_q;
`endif

    case (state_q)
      S_LOAD: begin
        buf_d   = {map7, map6, map5, map4, map3, map2, map1, map0};
        fs_d    = 1'b1;
        row_d   = 3'd0;
        cnt_d   = '0;
        state_d = AFTER_ROW;
`ifdef SCAN_DIM_EN
        bright_d = bright;
`endif
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          state_d = S_BLANK;
        end
      end
      S_ON: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (row_q == 3'd7) begin
            state_d = S_LOAD;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = AFTER_ROW;
          end
        end else begin
          state_d = S_ON;
        end
      end
      default: begin
        state_d = S_LOAD;
        row_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change on the same edge as it.
    if (state_d == S_ON) begin
      row_sel_d = 8'h01 << row_d;
      col_d     = buf_d[row_d];
`ifdef SCAN_DIM_EN
      if (dim_phase_s > bright_d) begin
        col_d = 8'h00;
      end else begin
        col_d = buf_d[row_d];
      end
`endif
    end else begin
      row_sel_d = 8'h00;
      col_d     = 8'h00;
    end
  end

  // State, counters, snapshot and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= S_LOAD;
      row_q     <= 3'd0;
      cnt_q     <= '0;
      buf_q     <= '0;
      row_sel_q <= 8'h00;
      col_q     <= 8'h00;
      fs_q      <= 1'b0;
`ifdef SCAN_DIM_EN
      bright_q  <= 3'd7;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fs_q      <= fs_d;
`ifdef SCAN_DIM_EN
      bright_q  <= bright_d;
`endif
    end
  end

  assign row_sel    = row_sel_q;
  assign col        = col_q;
  assign frame_sync = fs_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan (DWELL_CYC=4, BLANK_CYC=2 main instance,
// a BLANK_CYC=0 instance, and a DWELL_CYC=8 dimming instance when
// SCAN_DIM_EN is defined).
module tb_led_matrix_scan;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] m [8];
  logic [7:0] rs, cl, rs0, cl0;
  logic       fs, fs0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

`ifdef SCAN_DIM_EN
  logic [2:0] bright_lvl;
  logic [7:0] rsd, cld;
  logic       fsd;
`endif

  led_matrix_scan #(.DWELL_CYC(4), .BLANK_CYC(2)) u_dut (
    .CLK(clk), .CLR(clr),
    .map0(m[0]), .map1(m[1]), .map2(m[2]), .map3(m[3]),
    .map4(m[4]), .map5(m[5]), .map6(m[6]), .map7(m[7]),
`ifdef SCAN_DIM_EN
    .bright(3'd7),
`endif
    .row_sel(rs), .col(cl), .frame_sync(fs)
  );

  led_matrix_scan #(.DWELL_CYC(4), .BLANK_CYC(0)) u_dut0 (
    .CLK(clk), .CLR(clr),
    .map0(m[0]), .map1(m[1]), .map2(m[2]), .map3(m[3]),
    .map4(m[4]), .map5(m[5]), .map6(m[6]), .map7(m[7]),
`ifdef SCAN_DIM_EN
    .bright(3'd7),
`endif
    .row_sel(rs0), .col(cl0), .frame_sync(fs0)
  );

`ifdef SCAN_DIM_EN
  led_matrix_scan #(.DWELL_CYC(8), .BLANK_CYC(2)) u_dim (
    .CLK(clk), .CLR(clr),
    .map0(8'h00), .map1(8'h00), .map2(8'h00), .map3(8'h00),
    .map4(8'h00), .map5(8'hFF), .map6(8'h00), .map7(8'h00),
    .bright(bright_lvl),
    .row_sel(rsd), .col(cld), .frame_sync(fsd)
  );
`endif

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Advance until the selected instance shows frame_sync (bounded).
  task automatic wait_fs(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0 && fs === 1'b1) || (which == 1 && fs0 === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    m[0] = 8'h81;
    m[3] = 8'hF0;
    tick(2);
    tests++;
    if ({fs, rs, cl} !== 17'h0) begin
      fails++;
      $display("FAIL reset_hold: got fs=%b row_sel=%h col=%h, want 0/00/00", fs, rs, cl);
    end
    clr = 1'b1;
    tick(1);
    tests++;
    if (fs !== 1'b1 || rs !== 8'h00) begin
      fails++;
      $display("FAIL first_edge_sync: got fs=%b row_sel=%h, want 1/00", fs, rs);
    end
  endtask

  // Samples 2..49 of the first frame (sample 1 was the frame_sync cycle).
  task automatic test_basic_scan();
    logic [7:0] e_rs, e_cl;
    int row;
    for (int s = 2; s <= 49; s++) begin
      tick(1);
      e_rs = 8'h00;
      e_cl = 8'h00;
      if (s != 49 && ((s - 1) % 6) >= 2) begin
        row  = (s - 1) / 6;
        e_rs = 8'h01 << row;
        e_cl = m[row];
      end
      tests++;
      if (rs !== e_rs || cl !== e_cl || fs !== 1'b0) begin
        fails++;
        $display("FAIL basic_scan s=%0d: got fs=%b row_sel=%h col=%h, want 0/%h/%h",
                 s, fs, rs, cl, e_rs, e_cl);
      end
    end
  endtask

  task automatic test_frame_timing();
    bit ok;
    int n;
    wait_fs(0, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL frame_sync_timeout: got none in 200 cycles, want a pulse");
    end
    for (int f = 0; f < 2; f++) begin
      n = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        n++;
        if (fs === 1'b1) break;
      end
      tests++;
      if (n !== 49) begin
        fails++;
        $display("FAIL frame_period: got %0d, want 49", n);
      end
    end
  endtask

  task automatic test_tear_free();
    bit ok1, ok2, ok3;
    m[2] = 8'h0F;
    wait_fs(0, ok1);
    wait_fs(0, ok2);   // this frame definitely holds 8'h0F
    tick(8);           // sample 9: row 1 ON
    m[2] = 8'hAA;
    tick(6);           // sample 15: row 2 ON
    tests++;
    if (!ok1 || !ok2 || rs !== 8'h04 || cl !== 8'h0F) begin
      fails++;
      $display("FAIL tear_same_frame: got row_sel=%h col=%h, want 04/0f", rs, cl);
    end
    wait_fs(0, ok3);
    tick(14);
    tests++;
    if (!ok3 || rs !== 8'h04 || cl !== 8'hAA) begin
      fails++;
      $display("FAIL tear_next_frame: got row_sel=%h col=%h, want 04/aa", rs, cl);
    end
  endtask

  task automatic test_no_blank();
    bit ok;
    int n;
    logic [7:0] e_rs;
    wait_fs(1, ok);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (fs0 === 1'b1) break;
    end
    tests++;
    if (!ok || n !== 33) begin
      fails++;
      $display("FAIL noblank_period: got %0d, want 33", n);
    end
    for (int s = 1; s <= 33; s++) begin
      e_rs = (s == 33) ? 8'h00 : (8'h01 << ((s - 1) / 4));
      tests++;
      if (rs0 !== e_rs) begin
        fails++;
        $display("FAIL noblank_seq s=%0d: got row_sel=%h, want %h", s, rs0, e_rs);
      end
      tick(1);
    end
  endtask

`ifdef SCAN_DIM_EN
  task automatic test_dim();
    bit ok;
    logic [7:0] e_cl;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fsd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL dim_sync_timeout: got none in 300 cycles, want a pulse");
    end
    tick(52);          // sample 53: row 5 dwell cycle 0
    for (int c = 0; c < 8; c++) begin
      e_cl = (c <= 2) ? 8'hFF : 8'h00;
      tests++;
      if (rsd !== 8'h20 || cld !== e_cl) begin
        fails++;
        $display("FAIL dim c=%0d: got row_sel=%h col=%h, want 20/%h", c, rsd, cld, e_cl);
      end
      tick(1);
    end
  endtask
`endif

  task automatic test_async_reset();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rs !== 8'h00) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    clr = 1'b0;
    #1;                // still before the next rising edge
    tests++;
    if (!ok || rs !== 8'h00 || cl !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: got row_sel=%h col=%h, want 00/00", rs, cl);
    end
    @(negedge clk);
    clr = 1'b1;
    tick(1);
    tests++;
    if (fs !== 1'b1) begin
      fails++;
      $display("FAIL reset_restart: got fs=%b, want 1", fs);
    end
  endtask

  initial begin
`ifdef SCAN_DIM_EN
    bright_lvl = 3'd2;
`endif
    test_reset();
    test_basic_scan();
    test_frame_timing();
    test_tear_free();
    test_no_blank();
`ifdef SCAN_DIM_EN
    test_dim();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
